// File: rtl/rtttl_tone_arbiter.sv
// Shares one tone generator between the RTTTL music sequencer and a one-shot alert requester.
// Alerts preempt music, and every change of owner is padded with a silent guard interval.
module rtttl_tone_arbiter #(
   parameter int TICK_DIV    = 10000,
   parameter int GUARD_TICKS = 2,
   parameter int LEN_W       = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [3:0]       music_octave_i,
   input  logic [15:0]      music_note_i,
   input  logic             alert_req_i,
   input  logic [3:0]       alert_octave_i,
   input  logic [15:0]      alert_note_i,
   input  logic [LEN_W-1:0] alert_len_i,
   output logic             alert_ack_o,
   output logic             alert_done_o,
   output logic [3:0]       out_octave_o,
   output logic [15:0]      out_note_o,
   output logic             owner_o
);

   // state   | meaning
   // S_MUSIC | sequencer output forwarded to the tone generator
   // S_G2A   | silent guard before the alert tone (owner = alert)
   // S_ALERT | latched alert tone played for max(len,1) ticks
   // S_G2M   | silent guard before music resumes; a new alert may preempt it

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (LEN_W > 8) ? LEN_W : 8;

   typedef enum logic [1:0] {S_MUSIC, S_G2A, S_ALERT, S_G2M} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       aoct_q, aoct_d;
   logic [15:0]      anote_q, anote_d;
   logic [LEN_W-1:0] alen_q, alen_d;
   logic [3:0]       oct_q, oct_d;
   logic [15:0]      note_q, note_d;
   logic             own_q, own_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             tick, last_tick, accept;

   assign tick      = (presc_q == PW'(TICK_DIV - 1));
   assign last_tick = tick && (cnt_q <= CW'(1));
   assign accept    = alert_req_i && ((state_q == S_MUSIC) || (state_q == S_G2M));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_MUSIC;
         presc_q <= '0;
         cnt_q   <= '0;
         aoct_q  <= '0;
         anote_q <= '0;
         alen_q  <= '0;
         oct_q   <= '0;
         note_q  <= '0;
         own_q   <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         aoct_q  <= aoct_d;
         anote_q <= anote_d;
         alen_q  <= alen_d;
         oct_q   <= oct_d;
         note_q  <= note_d;
         own_q   <= own_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_MUSIC: if (accept) state_d = S_G2A;
         S_G2A:   if (last_tick) state_d = S_ALERT;
         S_ALERT: if (last_tick) state_d = S_G2M;
         S_G2M: begin
            if (accept)         state_d = S_G2A;
            else if (last_tick) state_d = S_MUSIC;
         end
         default: state_d = S_MUSIC;
      endcase
   end

   // Timebase restarts on every state entry so each state lasts an exact cycle count.
   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (state_d != state_q) begin
         presc_d = '0;
         case (state_d)
            S_G2A, S_G2M: cnt_d = CW'(GUARD_TICKS);
            S_ALERT:      cnt_d = (alen_q == '0) ? CW'(1) : CW'(alen_q);
            default:      cnt_d = '0;
         endcase
      end else if (tick) begin
         presc_d = '0;
         cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_comb begin
      aoct_d  = accept ? alert_octave_i : aoct_q;
      anote_d = accept ? alert_note_i   : anote_q;
      alen_d  = accept ? alert_len_i    : alen_q;
      oct_d   = oct_q;
      note_d  = '0;
      own_d   = 1'b0;
      case (state_d)
         S_MUSIC: begin
            oct_d  = music_octave_i;
            note_d = music_note_i;
         end
         S_G2A:   own_d = 1'b1;
         S_ALERT: begin
            oct_d  = aoct_q;
            note_d = anote_q;
            own_d  = 1'b1;
         end
         default: ;
      endcase
      ack_d  = accept;
      done_d = (state_q == S_ALERT) && (state_d == S_G2M);
   end

   assign alert_ack_o  = ack_q;
   assign alert_done_o = done_q;
   assign out_octave_o = oct_q;
   assign out_note_o   = note_q;
   assign owner_o      = own_q;

endmodule

// File: tb/tb_rtttl_tone_arbiter.sv
// Scoreboard bench for rtttl_tone_arbiter with TICK_DIV=4, GUARD_TICKS=2, LEN_W=8.
module tb_rtttl_tone_arbiter;
   localparam int TD = 4;
   localparam int GT = 2;
   localparam int LW = 8;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [3:0]    music_octave_i;
   logic [15:0]   music_note_i;
   logic          alert_req_i;
   logic [3:0]    alert_octave_i;
   logic [15:0]   alert_note_i;
   logic [LW-1:0] alert_len_i;
   logic          alert_ack_o, alert_done_o, owner_o;
   logic [3:0]    out_octave_o;
   logic [15:0]   out_note_o;

   rtttl_tone_arbiter #(.TICK_DIV(TD), .GUARD_TICKS(GT), .LEN_W(LW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .music_octave_i(music_octave_i), .music_note_i(music_note_i),
      .alert_req_i(alert_req_i), .alert_octave_i(alert_octave_i),
      .alert_note_i(alert_note_i), .alert_len_i(alert_len_i),
      .alert_ack_o(alert_ack_o), .alert_done_o(alert_done_o),
      .out_octave_o(out_octave_o), .out_note_o(out_note_o), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       tag;
      logic [15:0] note;
      logic [3:0]  oct;
      logic        chk_oct;
      logic        own;
      logic        ack;
      logic        done;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Push the expectation for the next edge, clock once, then pop and compare mid-cycle.
   task automatic step(input string tag, input logic [15:0] note, input logic [3:0] oct,
                       input logic chk_oct, input logic own, input logic ack, input logic done);
      exp_t e, r;
      e.tag = tag; e.note = note; e.oct = oct; e.chk_oct = chk_oct;
      e.own = own; e.ack = ack; e.done = done;
      sb.push_back(e);
      @(posedge clk_i);
      @(negedge clk_i);
      r = sb.pop_front();
      chk({r.tag, "/note"}, 32'(out_note_o), 32'(r.note));
      if (r.chk_oct) chk({r.tag, "/oct"}, 32'(out_octave_o), 32'(r.oct));
      chk({r.tag, "/owner"}, 32'(owner_o), 32'(r.own));
      chk({r.tag, "/ack"}, 32'(alert_ack_o), 32'(r.ack));
      chk({r.tag, "/done"}, 32'(alert_done_o), 32'(r.done));
   endtask

   // Step 0 is the ack cycle. With raise2, a second request is raised mid-alert and the
   // sequence stops at the done cycle so the caller can continue with the second alert.
   task automatic do_alert(input string tag, input logic [3:0] a_oct, input logic [15:0] a_note,
                           input logic [LW-1:0] len, input logic [3:0] prev_oct,
                           input logic prev_known, input logic raise2, input logic [3:0] b_oct,
                           input logic [15:0] b_note, input logic [LW-1:0] b_len);
      int lt;
      int d;
      lt = (len == 0) ? 1 : int'(len);
      d  = GT * TD + lt * TD;
      alert_req_i    = 1'b1;
      alert_octave_i = a_oct;
      alert_note_i   = a_note;
      alert_len_i    = len;
      for (int k = 0; k <= d; k++) begin
         if (k == 1) alert_req_i = 1'b0;
         if (raise2 && k == GT * TD + 2) begin
            alert_req_i    = 1'b1;
            alert_octave_i = b_oct;
            alert_note_i   = b_note;
            alert_len_i    = b_len;
         end
         if (k < GT * TD)  step({tag, "_g2a"}, 16'h0, prev_oct, prev_known, 1'b1, k == 0, 1'b0);
         else if (k < d)   step({tag, "_alert"}, a_note, a_oct, 1'b1, 1'b1, 1'b0, 1'b0);
         else              step({tag, "_done"}, 16'h0, a_oct, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (!raise2) begin
         for (int k = 1; k < GT * TD; k++)
            step({tag, "_g2m"}, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         step({tag, "_resume"}, music_note_i, music_octave_i, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rstn_i         = 1'b0;
      music_octave_i = 4'd7;
      music_note_i   = 16'h1234;
      alert_req_i    = 1'b0;
      alert_octave_i = 4'd0;
      alert_note_i   = 16'h0;
      alert_len_i    = '0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("rst_note", 32'(out_note_o), 32'h0);
         chk("rst_oct", 32'(out_octave_o), 32'h0);
         chk("rst_owner", 32'(owner_o), 32'h0);
         chk("rst_ack", 32'(alert_ack_o), 32'h0);
         chk("rst_done", 32'(alert_done_o), 32'h0);
      end
      rstn_i = 1'b1;

      music_octave_i = 4'd5;
      music_note_i   = 16'h01A3;
      step("pass", 16'h01A3, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);

      music_octave_i = 4'd3;
      music_note_i   = 16'h0777;
      step("music", 16'h0777, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      do_alert("basic", 4'd6, 16'h0100, 8'd3, 4'd3, 1'b1, 1'b0, 4'd0, 16'h0, 8'd0);

      do_alert("first", 4'd1, 16'h0AAA, 8'd2, 4'd3, 1'b1, 1'b1, 4'd9, 16'h0BBB, 8'd1);
      do_alert("second", 4'd9, 16'h0BBB, 8'd1, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, 8'd0);

      do_alert("len0", 4'd4, 16'h0222, 8'd0, 4'd3, 1'b1, 1'b0, 4'd0, 16'h0, 8'd0);

      alert_req_i    = 1'b1;
      alert_octave_i = 4'd2;
      alert_note_i   = 16'h0333;
      alert_len_i    = 8'd5;
      for (int k = 0; k < GT * TD + 2; k++) begin
         if (k == 1) alert_req_i = 1'b0;
         if (k < GT * TD) step("abort_g2a", 16'h0, 4'd3, 1'b1, 1'b1, k == 0, 1'b0);
         else             step("abort_alert", 16'h0333, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      rstn_i = 1'b0;
      #1;
      chk("abort_note", 32'(out_note_o), 32'h0);
      chk("abort_oct", 32'(out_octave_o), 32'h0);
      chk("abort_owner", 32'(owner_o), 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("abort_done", 32'(alert_done_o), 32'h0);
         chk("abort_ack", 32'(alert_ack_o), 32'h0);
      end
      rstn_i = 1'b1;
      for (int k = 0; k < 30; k++)
         step("after_abort", 16'h0777, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);

      music_octave_i = 4'd2;
      music_note_i   = 16'h0;
      step("rest", 16'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      do_alert("rest_alert", 4'd6, 16'h0100, 8'd3, 4'd2, 1'b1, 1'b0, 4'd0, 16'h0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rtttl_tone_arbiter.md
Name: rtttl_tone_arbiter

Overview:
- Shares the single downstream tone generator between two requesters:
  - the RTTTL music sequencer, which drives octave/note continuously;
  - an alert requester, which issues one-shot beeps of a fixed length.
- Alerts preempt music. A silent guard interval is inserted at every ownership change to avoid clicks.
- Music resumes automatically after an alert.
- Sits between rtttl_sequencer and the tone generator.

Parameters:
- TICK_DIV, default 10000: clk cycles per timing tick. Legal range 2..65535.
- GUARD_TICKS, default 2: ticks of forced silence on each ownership change. Legal range 1..255.
- LEN_W, default 8: width of alert_len.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- music_octave, input, 4: octave from the sequencer.
- music_note, input, 16: note from the sequencer. 0 = rest.
- alert_req, input, 1: alert request level. Held high until alert_ack.
- alert_octave, input, 4: alert octave. Sampled on acceptance.
- alert_note, input, 16: alert note. Sampled on acceptance.
- alert_len, input, LEN_W: alert duration in ticks. Sampled on acceptance.
- alert_ack, output, 1: one-cycle pulse when the request is accepted.
- alert_done, output, 1: one-cycle pulse when the alert tone ends.
- out_octave, output, 4: octave to the tone generator.
- out_note, output, 16: note to the tone generator.
- owner, output, 1: 0 = music, 1 = alert (covers guard-to-alert and alert states).

Behaviour:
- Reset (async, rstn low):
  - state = MUSIC; prescaler = 0; tick counter = 0;
  - out_octave = 0, out_note = 0, owner = 0, alert_ack = 0, alert_done = 0.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick when it wraps.
  - Cleared on every state entry, so each state's duration is exact in cycles.
- Tick counter: loaded on state entry, decremented on tick. The state exits on the tick that brings it to 0.
- MUSIC:
  - out_* <= music_* every cycle (1-cycle latency); owner = 0.
  - If alert_req = 1: latch alert_octave, alert_note and alert_len; pulse alert_ack next cycle; go to G2A.
- G2A (guard to alert):
  - out_note = 0, out_octave holds its value; owner = 1.
  - Duration GUARD_TICKS*TICK_DIV cycles, then go to ALERT.
- ALERT:
  - out_* = latched alert values; owner = 1.
  - Duration max(alert_len,1)*TICK_DIV cycles. alert_len = 0 is treated as 1.
  - On exit: pulse alert_done for 1 cycle (the first cycle of G2M); go to G2M.
- G2M (guard to music):
  - out_note = 0; owner = 0.
  - Duration GUARD_TICKS*TICK_DIV cycles, then go to MUSIC.
  - If alert_req = 1 during G2M: accept immediately (latch, ack next cycle) and go to G2A. The prescaler restarts and the guard counts from full.
- alert_req in G2A or ALERT: ignored, no ack. The requester keeps it high; it is accepted on return to G2M or MUSIC.
- Total cycles from ack to alert_done = (GUARD_TICKS + max(alert_len,1))*TICK_DIV.
- Music is not buffered or paused: the sequencer keeps running, and music_* is simply not forwarded while owner ≠ music or during G2M.
- rstn low mid-alert: immediate return to reset values. No alert_done is emitted for the aborted alert.
- The ack and done pulses are never stretched. The ack and done for back-to-back alerts are at least 1 cycle apart.
- Counter widths:
  - prescaler: ceil(log2(TICK_DIV)) bits;
  - tick counter: max(LEN_W, 8) bits;
  - no overflow for legal parameters.

Test Plan (TICK_DIV=4, GUARD_TICKS=2, LEN_W=8):
1. Reset and pass-through.
   - Hold rstn low 3 cycles: all outputs = 0.
   - Release, then drive music_octave=5, music_note=16'h01A3: out_* = 5/01A3 one cycle later; owner = 0.
2. Basic alert.
   - In MUSIC, alert_req=1 with alert_note=16'h0100, alert_octave=6, alert_len=3.
   - alert_ack pulses the next cycle.
   - out_note = 0 for 8 cycles; then 0100/6 for 12 cycles.
   - alert_done pulses at cycle 20 after ack; out_note = 0 for 8 more cycles; then music_note is forwarded again.
3. Request during ALERT.
   - Raise a second alert_req mid-ALERT: no ack until the first cycle of G2M.
   - The second G2A is a full 8 cycles of silence.
   - The second alert's values are used; the first alert's values are not.
4. alert_len = 0: alert tone lasts exactly 4 cycles (1 tick), with a single done pulse.
5. Reset mid-alert: assert rstn low during ALERT → outputs = 0 asynchronously; no alert_done; MUSIC after release.
6. Music rest forwarded: music_note = 0 in MUSIC → out_note = 0 while owner = 0; alert_req then behaves exactly as in scenario 2.
